// File: rtl/param_calc_if.sv
// param_calc_if: request/result bundle for the param_calc integer calculator.
//
// Signals (W = operand width):
//   Go    start request, honoured only while the calculator is idle
//   X, Y  W-bit unsigned operands
//   F     3-bit opcode
//   Done  one-cycle completion pulse (also on error completions)
//   Busy  high while an operation is being loaded or executed
//   H, L  2W-bit result split into high/low halves (remainder/quotient for DIV)
//   CS    current controller state code, zero-extended to 4 bits
//   Err   sticky error flag (divide by zero or invalid opcode)
//
// master: the requester side; slave: the calculator side.
interface param_calc_if #(
  parameter int W = 4
);
  logic         Go;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic [2:0]   F;
  logic         Done;
  logic         Busy;
  logic [W-1:0] H;
  logic [W-1:0] L;
  logic [3:0]   CS;
  logic         Err;

  modport master (
    output Go, X, Y, F,
    input  Done, Busy, H, L, CS, Err
  );

  modport slave (
    input  Go, X, Y, F,
    output Done, Busy, H, L, CS, Err
  );
endinterface

// File: rtl/param_calc.sv
// param_calc: W-bit multi-function integer calculator.
//
// Captures X, Y and F when Go is accepted in IDLE, then either computes a
// single-cycle logic/arithmetic result (ADD, SUB, AND, XOR) or runs W
// iterations of a shared shift-add multiplier / restoring divider (MUL, SQR,
// DIV). The 2W-bit result is returned as H/L together with a one-cycle Done.
// DIV by zero and opcode 111 complete through the ERR state, which clears
// H/L and raises the sticky Err flag.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-low reset
//   bus  param_calc_if.slave (Go/X/Y/F in; Done/Busy/H/L/CS/Err out)
module param_calc #(
  parameter int W = 4
) (
  input  logic          clk,
  input  logic          rst,
  param_calc_if.slave   bus
);

  localparam int CW = $clog2(W + 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;
  localparam logic [2:0] OP_SQR = 3'd5;
  localparam logic [2:0] OP_DIV = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_EXEC = 3'd2,
    S_ITER = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [W-1:0]  xr;
  logic [W-1:0]  yr;
  logic [2:0]    fr;
  logic [W-1:0]  mcand;
  logic [CW-1:0] cnt;
  // Shared iterative register. MUL/SQR: bits [2W:W] accumulate partial sums,
  // the low half holds the multiplier being shifted out. DIV: [2W-1:W] is
  // the partial remainder and [W-1:0] the dividend/quotient.
  logic [2*W:0]  acc;

  logic [W-1:0]  h_q;
  logic [W-1:0]  l_q;
  logic          done_q;
  logic          err_q;

  logic [W:0]    add_sum;
  logic [W-1:0]  exec_h;
  logic [W-1:0]  exec_l;

  logic [W:0]    mul_sum;
  logic [2*W:0]  mul_next;
  logic [W:0]    div_shift;
  logic          div_fits;
  logic [W-1:0]  div_rem;
  logic [2*W:0]  div_next;
  logic [2*W:0]  iter_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (bus.Go) begin
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!fr[2]) begin
          state_next = S_EXEC;
        end else if (fr == OP_MUL || fr == OP_SQR) begin
          state_next = S_ITER;
        end else if (fr == OP_DIV && yr != '0) begin
          state_next = S_ITER;
        end else begin
          state_next = S_ERR;
        end
      end
      S_EXEC: state_next = S_DONE;
      S_ITER: begin
        if (cnt == CW'(1)) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Single-cycle results from the captured operands.
  always_comb begin
    add_sum = {1'b0, xr} + {1'b0, yr};
    exec_h  = '0;
    exec_l  = '0;
    case (fr)
      OP_ADD: begin
        exec_h = {{(W-1){1'b0}}, add_sum[W]};
        exec_l = add_sum[W-1:0];
      end
      OP_SUB: begin
        exec_h = {W{xr < yr}};
        exec_l = xr - yr;
      end
      OP_AND: exec_l = xr & yr;
      OP_XOR: exec_l = xr ^ yr;
      default: begin
        exec_h = '0;
        exec_l = '0;
      end
    endcase
  end

  // One iteration of the shared engine. The multiplier adds the multiplicand
  // into the upper half when the current multiplier bit is set and then
  // shifts right; the divider shifts {remainder, quotient} left by one and
  // keeps the trial subtraction only when the divisor fits.
  always_comb begin
    mul_sum = acc[2*W:W];
    if (acc[0]) begin
      mul_sum = acc[2*W:W] + {1'b0, mcand};
    end
    mul_next  = {1'b0, mul_sum, acc[W-1:1]};

    div_shift = acc[2*W-1:W-1];
    div_fits  = (div_shift >= {1'b0, yr});
    div_rem   = div_fits ? W'(div_shift - {1'b0, yr}) : div_shift[W-1:0];
    div_next  = {1'b0, div_rem, acc[W-2:0], div_fits};

    iter_next = (fr == OP_DIV) ? div_next : mul_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xr     <= '0;
      yr     <= '0;
      fr     <= '0;
      mcand  <= '0;
      cnt    <= '0;
      acc    <= '0;
      h_q    <= '0;
      l_q    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.Go) begin
            xr    <= bus.X;
            yr    <= bus.Y;
            fr    <= bus.F;
            err_q <= 1'b0;
          end
        end
        S_LOAD: begin
          // SQR reuses X as the multiplier; DIV starts with X as dividend.
          cnt   <= CW'(W);
          mcand <= xr;
          acc   <= {{(W+1){1'b0}}, (fr == OP_MUL) ? yr : xr};
        end
        S_EXEC: begin
          h_q    <= exec_h;
          l_q    <= exec_l;
          done_q <= 1'b1;
        end
        S_ITER: begin
          acc <= iter_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            h_q    <= iter_next[2*W-1:W];
            l_q    <= iter_next[W-1:0];
            done_q <= 1'b1;
          end
        end
        S_ERR: begin
          h_q    <= '0;
          l_q    <= '0;
          err_q  <= 1'b1;
          done_q <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.Done = done_q;
  assign bus.Busy = (state == S_LOAD) || (state == S_EXEC) || (state == S_ITER);
  assign bus.H    = h_q;
  assign bus.L    = l_q;
  assign bus.CS   = {1'b0, state};
  assign bus.Err  = err_q;

endmodule

// File: doc/param_calc.md
# param_calc

Parametrised multi-function integer calculator: captures two W-bit unsigned operands and a 3-bit opcode on a Go request, executes single-cycle logic/arithmetic or iterative multiply/square/divide, and returns a 2W-bit result as H/L with a one-cycle Done pulse. It is the next-generation calculator top for the board-level designs: control unit and datapath in one block, generalised from a fixed 4-bit width to W bits, with an iterative shared multiply/divide engine, a Busy output and a sticky error flag.

## Interface
- W, default 4: operand width; H and L are each W bits; legal range 2..16.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- Go  in  1  start request; sampled only in IDLE.
- X  in  W  operand A (unsigned).
- Y  in  W  operand B (unsigned).
- F  in  3  opcode.
- Done  out  1  one-cycle completion pulse, including error completions.
- Busy  out  1  high in LOAD, EXEC and ITER.
- H  out  W  result high half (remainder for DIV).
- L  out  W  result low half (quotient for DIV).
- CS  out  4  current state code, zero-extended.
- Err  out  1  sticky error flag.

## Operation
- **Opcodes:**
  - 000 ADD: {H,L} = X+Y; H = carry in bit 0, other H bits 0.
  - 001 SUB: L = (X−Y) mod 2^W; H = all ones if X<Y, else 0.
  - 010 AND: L = X&Y, H = 0.
  - 011 XOR: L = X^Y, H = 0.
  - 100 MUL: {H,L} = X*Y.
  - 101 SQR: {H,L} = X*X; Y is ignored.
  - 110 DIV: L = X/Y, H = X%Y.
  - 111: invalid.
- **Operand capture:** X, Y and F are registered on the edge that accepts Go. Later input changes have no effect on the operation in progress.
- **State codes:** IDLE=0, LOAD=1, EXEC=2, ITER=3, DONE=4, ERR=5.
- **Transitions:**
  - IDLE: Go=1 → LOAD, capturing operands. Err clears on the same edge.
  - LOAD: F in 000–011 → EXEC. MUL/SQR → ITER with counter=W. DIV with Y≠0 → ITER with counter=W. DIV with Y=0, or F=111 → ERR.
  - EXEC: registers H/L → DONE.
  - ITER: one iteration per cycle. The counter decrements each cycle. At counter=1, H/L are written on that edge → DONE.
  - DONE → IDLE unconditionally.
  - ERR: sets Err=1, H=0, L=0 → IDLE.
- **MUL/SQR algorithm:** shift-add. Each cycle, if the multiplier LSB is 1, add the multiplicand into the upper half of a 2W+1-bit accumulator. Then shift the accumulator right by 1.
- **DIV algorithm:** restoring division, W iterations on a {remainder, quotient} shift register, one quotient bit per cycle, MSB first.
- **Go while busy:** Go outside IDLE is ignored. No queuing.
- **Go held high:** the block restarts one cycle after DONE or ERR, because IDLE accepts Go on the next edge.
- **Output hold:** H and L hold the last result until the next completed operation overwrites them or ERR clears them.
- **Err:** stays high until the next accepted Go or reset.
- **Reset mid-operation:** asynchronous, regardless of state. Forces IDLE and clears all outputs and internal registers. No partial result is retained.

## Timing
- **Reset values:**
  - Done=0, Busy=0, Err=0.
  - H=0, L=0.
  - CS=0 (IDLE).
  - Iteration counter=0.
- All outputs are registered; none is combinational from inputs.
- Let e0 be the edge that accepts Go. "State after eN" means the state that holds once edge eN has occurred.
- **ADD/SUB/AND/XOR:** LOAD after e0, EXEC after e1, DONE after e2. Done and valid H/L are visible after e2, a latency of 3 cycles.
- **MUL/SQR/DIV:** ITER after e1 through eW, DONE after eW+1. Latency is W+2 cycles.
- **DIV by zero or F=111:** ERR after e1. Done=1 and Err=1 are visible after e2. Latency is 3 cycles.
- **Done pulse:** exactly one cycle wide. Busy is deasserted in the same cycle Done asserts.
- **Back-to-back:** earliest next accept is the edge after the Done cycle, so a single-cycle op has 4-cycle throughput.

## Test plan
- W=4, ADD X=9 Y=8 → H=1, L=1; Done high exactly one cycle, after e2; CS sequence 0,1,2,4,0.
- W=4, SUB X=3 Y=5 → L=14, H=15, Err=0. Then XOR X=12 Y=10 → L=6, H=0.
- W=4, MUL X=15 Y=15 → H=14, L=1, Done after e5; SQR X=7 with Y=3 → H=3, L=1. Repeat the MUL with W=8, X=255 Y=255 → H=0xFE, L=0x01, Done after e9.
- W=4, DIV X=13 Y=4 → L=3, H=1. DIV X=5 Y=0 → Err=1, H=0, L=0, Done after e2, CS passes through 5; Err stays 1 until the next Go, then clears on that accept edge.
- W=4, F=111 → Err=1, Done pulse. Assert Go repeatedly during a MUL in ITER → ignored, result unchanged. Toggle X/Y after e0 → result unaffected.
- W=4, assert rst low asynchronously mid-ITER of a DIV → CS=0, H=L=0, Busy=0, Done=0 immediately. After release, a new ADD X=1 Y=1 → L=2.
